// File: rtl/mont_pkg.sv
// mont_pkg: constants, helpers and shared types for the Montgomery pipeline.
//   MONT_N, MONT_N_INV, MONT_R2 : modulus 2^64-15 and its Montgomery constants
//   mont_reduce_once            : single conditional subtract of N (valid for w < 2N)
//   mont_pair_t                 : operand pair {a, b}
//   pair_state_t                : pairing FSM states
package mont_pkg;
   localparam logic [63:0] MONT_N     = 64'hFFFFFFFFFFFFFFF1;
   localparam logic [63:0] MONT_N_INV = 64'heeeeeeeeeeeeeeef;
   localparam logic [63:0] MONT_R2    = 64'he1;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
   } mont_pair_t;

   typedef enum logic {
      ST_EMPTY,
      ST_HOLD_A
   } pair_state_t;

   // Any 64-bit word is below 2N, so one subtraction fully reduces it.
   function automatic logic [63:0] mont_reduce_once(input logic [63:0] w);
      return (w >= MONT_N) ? w - MONT_N : w;
   endfunction
endpackage

// File: rtl/mont_pair_fifo.sv
// mont_pair_fifo: small synchronous FIFO of operand pairs.
//   clk, rst   : clock, asynchronous active-high reset (storage cleared)
//   push       : write push_data (ignored when full unless popping)
//   push_data  : pair to store
//   pop        : remove head (ignored when empty)
//   head       : head entry, registered storage only
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
module mont_pair_fifo
   import mont_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  mont_pair_t               push_data,
   input  logic                     pop,
   output mont_pair_t               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   mont_pair_t        mem_q [DEPTH];
   logic [AW-1:0]     wr_q;
   logic [AW-1:0]     rd_q;
   logic [AW:0]       cnt_q;
   logic              do_pop;
   logic              do_push;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO may still accept.
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_q];
   assign count   = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= wr_q + AW'(1);
         end
         if (do_pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end
endmodule

// File: rtl/mont_operand_pairer.sv
// mont_operand_pairer: reduces incoming words mod N and pairs them into (a, b) operands.
//   word_in, word_last, taken, ready_in : word stream handshake (accept = taken && ready_in)
//   a, b, ready_out, given              : head pair handshake (pop = given && ready_out)
//   pair_count                          : pairs pushed since reset, wraps at 2^16
//   drop                                : sticky, a word arrived while ready_in was low
module mont_operand_pairer
   import mont_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] word_in,
   input  logic        word_last,
   input  logic        taken,
   output logic        ready_in,
   output logic [63:0] a,
   output logic [63:0] b,
   output logic        ready_out,
   input  logic        given,
   output logic [15:0] pair_count,
   output logic        drop
);
   pair_state_t              state_q, state_d;
   logic [63:0]              a_hold_q, a_hold_d;
   logic [15:0]              pair_count_q;
   logic                     drop_q;
   logic [63:0]              red;
   logic                     accept;
   logic                     pop;
   logic                     push;
   mont_pair_t               push_data;
   mont_pair_t               head;
   logic [$clog2(DEPTH):0]   count;
   logic                     full;
   logic                     empty;

   assign red       = mont_reduce_once(word_in);
   assign ready_out = !empty;
   assign pop       = given && ready_out;
   // Conservative: low whenever full, even if the next word would only be held.
   assign ready_in  = !full || pop;
   assign accept    = taken && ready_in;
   assign a         = head.a;
   assign b         = head.b;
   assign pair_count = pair_count_q;
   assign drop      = drop_q;

   always_comb begin
      state_d   = state_q;
      a_hold_d  = a_hold_q;
      push      = 1'b0;
      push_data = '{a: red, b: 64'd1};
      if (accept) begin
         if (state_q == ST_HOLD_A) begin
            push      = 1'b1;
            push_data = '{a: a_hold_q, b: red};
            state_d   = ST_EMPTY;
         end else if (word_last) begin
            push = 1'b1;
         end else begin
            a_hold_d = red;
            state_d  = ST_HOLD_A;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         a_hold_q     <= '0;
         pair_count_q <= '0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_hold_q     <= a_hold_d;
         pair_count_q <= pair_count_q + {15'd0, push};
         drop_q       <= drop_q | (taken && !ready_in);
      end
   end

   mont_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );
endmodule

// File: tb/tb_mont_operand_pairer.sv
// tb_mont_operand_pairer: scoreboard bench for mont_operand_pairer.
module tb_mont_operand_pairer;
   import mont_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [63:0] N = 64'hFFFFFFFFFFFFFFF1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] word_in = '0;
   logic        word_last = 1'b0;
   logic        taken = 1'b0;
   logic        ready_in;
   logic [63:0] a;
   logic [63:0] b;
   logic        ready_out;
   logic        given = 1'b0;
   logic [15:0] pair_count;
   logic        drop;

   int n_checks = 0;
   int n_err = 0;

   mont_pair_t  exp_q[$];
   logic        m_hold_v;
   logic [63:0] m_hold;
   logic [15:0] m_pc;
   logic        m_drop;

   mont_operand_pairer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .word_in    (word_in),
      .word_last  (word_last),
      .taken      (taken),
      .ready_in   (ready_in),
      .a          (a),
      .b          (b),
      .ready_out  (ready_out),
      .given      (given),
      .pair_count (pair_count),
      .drop       (drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic tk, input logic [63:0] w, input logic last, input logic gv);
      taken = tk;
      word_in = w;
      word_last = last;
      given = gv;
      @(posedge clk);
      #1;
   endtask

   // Reference model, evaluated mid-cycle when inputs are stable.
   always @(negedge clk) begin
      logic        pop_e, rdy_e;
      logic [63:0] r;
      if (rst) begin
         exp_q.delete();
         m_hold_v = 1'b0;
         m_hold = '0;
         m_pc = '0;
         m_drop = 1'b0;
      end else begin
         pop_e = given && exp_q.size() != 0;
         rdy_e = exp_q.size() < DEPTH || pop_e;
         check("ready_out", ready_out, exp_q.size() != 0);
         check("ready_in", ready_in, rdy_e);
         check("pair_count", pair_count, m_pc);
         check("drop", drop, m_drop);
         if (pop_e) begin
            check("head_a", a, exp_q[0].a);
            check("head_b", b, exp_q[0].b);
            void'(exp_q.pop_front());
         end
         if (taken && !rdy_e) m_drop = 1'b1;
         if (taken && rdy_e) begin
            r = (word_in >= N) ? word_in - N : word_in;
            if (m_hold_v) begin
               exp_q.push_back('{a: m_hold, b: r});
               m_hold_v = 1'b0;
               m_pc = m_pc + 16'd1;
            end else if (word_last) begin
               exp_q.push_back('{a: r, b: 64'd1});
               m_pc = m_pc + 16'd1;
            end else begin
               m_hold = r;
               m_hold_v = 1'b1;
            end
         end
      end
   end

   initial begin
      #5_000_000;
      n_err++;
      $display("FAIL watchdog timeout");
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #1;
      check("rst_ready_in", ready_in, 1);
      check("rst_ready_out", ready_out, 0);
      check("rst_a", a, 0);
      check("rst_b", b, 0);
      check("rst_pc", pair_count, 0);
      check("rst_drop", drop, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // basic pair, reduction, last-word pairs
      step(1, 64'd5, 0, 1);
      step(1, 64'd7, 0, 1);
      check("p57_ready", ready_out, 1);
      check("p57_a", a, 64'd5);
      check("p57_b", b, 64'd7);
      check("p57_pc", pair_count, 16'd1);
      step(1, 64'hFFFFFFFFFFFFFFF1, 0, 1);
      step(1, 64'hFFFFFFFFFFFFFFFF, 0, 1);
      check("red_a", a, 64'd0);
      check("red_b", b, 64'd14);
      step(1, 64'hFFFFFFFFFFFFFFF0, 1, 1);
      check("pass_a", a, 64'hFFFFFFFFFFFFFFF0);
      check("pass_b", b, 64'd1);
      step(1, 64'd9, 1, 1);
      check("last_a", a, 64'd9);
      check("last_b", b, 64'd1);
      step(1, 64'd3, 0, 1);
      step(1, 64'd4, 1, 1);
      check("p34_a", a, 64'd3);
      check("p34_b", b, 64'd4);
      step(0, 0, 0, 1);
      check("p34_only", ready_out, 0);

      // fill, overflow, simultaneous push/pop when full, drain
      for (int i = 0; i < 2 * DEPTH; i++) step(1, 64'(100 + i), 0, 0);
      check("full_ready_in", ready_in, 0);
      step(1, 64'd99, 0, 0);
      check("drop_set", drop, 1);
      step(1, 64'd50, 1, 1);
      step(0, 0, 0, 0);
      check("still_full", ready_in, 0);
      for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 1);
      check("drained", ready_out, 0);
      check("drop_sticky", drop, 1);

      // asynchronous reset mid-cycle with a held word and a buffered pair
      step(1, 64'd20, 1, 0);
      step(1, 64'd11, 0, 0);
      taken = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_ready_out", ready_out, 0);
      check("arst_ready_in", ready_in, 1);
      check("arst_a", a, 0);
      check("arst_b", b, 0);
      check("arst_pc", pair_count, 0);
      check("arst_drop", drop, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step(0, 0, 0, 1);
      check("arst_no_pair", ready_out, 0);
      step(1, 64'd1, 0, 1);
      step(1, 64'd2, 0, 1);
      check("post_a", a, 64'd1);
      check("post_b", b, 64'd2);

      // pair_count wrap
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 65535; i++) step(1, 64'(i), 1, 1);
      check("pc_ffff", pair_count, 16'hFFFF);
      step(1, 64'd7, 1, 1);
      check("pc_wrap", pair_count, 16'h0000);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/mont_operand_pairer.md
# mont_operand_pairer

Upstream feeder for `montgomery_top`. Accepts a single stream of 64-bit words, pre-reduces each word modulo N = 2^64−15, and pairs consecutive words into (a, b) operand pairs. An odd trailing word, marked by `word_last`, is paired with b = 1. Completed pairs are buffered in a small FIFO and presented on the same `taken`/`ready_in`/`ready_out`/`given` handshake used throughout the Montgomery pipeline.

## Interface
- `DEPTH`, default 4: pair FIFO entries; power of two, ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `word_in`  in  64  incoming operand word.
- `word_last`  in  1  qualifies `word_in` as the final word of a group.
- `taken`  in  1  upstream presents `word_in`; the word is accepted when `ready_in` = 1.
- `ready_in`  out  1  block can accept a word this cycle.
- `a`  out  64  head pair, first operand (reduced).
- `b`  out  64  head pair, second operand (reduced, or 1).
- `ready_out`  out  1  head pair valid.
- `given`  in  1  downstream consumed the head pair this cycle.
- `pair_count`  out  16  pairs pushed since reset; wraps at 2^16.
- `drop`  out  1  sticky: a word was presented while `ready_in` = 0.

## Operation
- Reduction of every accepted word w: `red(w) = (w >= N) ? w − N : w`. One subtraction is sufficient because w < 2N. Compare and subtract are 64-bit unsigned.
- Pairing FSM states:
  - EMPTY: no held word.
  - HOLD_A: `a_hold` register valid.
- Transitions on an accepted word:
  - EMPTY, `word_last` = 0: `a_hold` ← red(w); go to HOLD_A. Nothing is pushed.
  - EMPTY, `word_last` = 1: push {red(w), 64'd1}; stay in EMPTY.
  - HOLD_A, any `word_last`: push {a_hold, red(w)}; go to EMPTY.
- FIFO:
  - Push = pair completion.
  - Pop = `given` && `ready_out`. `given` while empty is ignored.
  - `ready_out` = (count ≠ 0).
  - `a`/`b` show the head entry. They are don't-care when empty but driven from storage (never X after reset).
- `ready_in` = !full || (`given` && `ready_out`). This is conservative: ready is low when full, regardless of FSM state.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, a push and a pop in the same cycle are legal.
- `taken` with `ready_in` = 0: the word is discarded, FSM and FIFO are unchanged, and `drop` ← 1. Only `rst` clears `drop`.
- `pair_count` increments by 1 on every push, including last-word pairs. It wraps from 16'hFFFF to 0.

## Timing
- Reset values:
  - `ready_in` = 1, `ready_out` = 0.
  - `a` = 0, `b` = 0 (all FIFO storage cleared).
  - `pair_count` = 0, `drop` = 0.
  - FSM = EMPTY, `a_hold` = 0.
- Reset mid-operation: a held A word and all buffered pairs are lost. No pair is emitted after reset deasserts until new words arrive.
- Latency: a pair is pushed at the edge that accepts its completing word. `ready_out` rises in the following cycle, so latency is 1 cycle from the completing `taken`.
- Throughput: one word per cycle. A full pair takes 2 cycles; a last-word pair takes 1 cycle.
- `ready_in` has a combinational path from `given`. `ready_out`, `a`, and `b` are registered-only, with no path from inputs.
- The FIFO is full at count = DEPTH. Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

## Structure
- Shared package `mont_pkg` holds:
  - constants `MONT_N` = 64'hFFFFFFFFFFFFFFF1, `MONT_N_INV` = 64'heeeeeeeeeeeeeeef, `MONT_R2` = 64'he1;
  - function `mont_reduce_once(logic [63:0])`;
  - typedef `mont_pair_t` (struct {a, b}).
- The existing Montgomery stages are refactored to import `MONT_N`, `MONT_N_INV`, and `MONT_R2` from `mont_pkg`.
- Sub-module `mont_pair_fifo`:
  - parameter `DEPTH`, storing `mont_pair_t`;
  - ports: `clk`, `rst`, push, `push_data`, pop, `head`, `count`, full, empty.
- The pairing FSM, reduction, counters, and handshake glue live in `mont_operand_pairer`.

## Test plan
- Words 5, 7 (not last) with `given` held 1 → one pair a=5, b=7; `ready_out` high exactly 1 cycle after the second `taken`; `pair_count` = 1.
- Words 64'hFFFFFFFFFFFFFFF1, 64'hFFFFFFFFFFFFFFFF → pair a=0, b=14. Word 64'hFFFFFFFFFFFFFFF0 → passes unchanged.
- Single word 9 with `word_last` = 1 → pair a=9, b=1 next cycle; FSM back in EMPTY. Words 3, 4(last) → a=3, b=4 with no extra pair.
- `given` = 0, stream 2×DEPTH words → `ready_in` falls after the DEPTH-th push; one extra `taken` sets `drop` = 1 and state is unchanged. Then pulse `given` with `taken` in the same cycle → count stays DEPTH, and pairs drain in order.
- Accept word 11 (HOLD_A), assert `rst` asynchronously mid-cycle → all outputs immediately at reset values. After release, words 1, 2 → pair a=1, b=2 (11 not emitted).
- Preload `pair_count` to 16'hFFFF via 65535 last-word pushes with `given` = 1 → the next push wraps `pair_count` to 0.
